mike_cacheline_adaptor: RTL and testbench

//   Memory-side stage directly downstream of mike_cache_datapath / cache control.

---
 rtl/mike_cacheline_adaptor_if.sv | 29 ++
 rtl/mike_cacheline_adaptor.sv | 102 ++++++++++
 tb/tb_mike_cacheline_adaptor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mike_cacheline_adaptor_if.sv
// Cache-side and memory-side handshake bundle for the cacheline/burst adaptor.
// The adaptor connects through the slave modport; the driver of both sides uses master.
interface mike_cacheline_adaptor_if #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
);
  logic [31:0]        address_i;
  logic [s_line-1:0]  line_i;
  logic               read_i;
  logic               write_i;
  logic [s_line-1:0]  line_o;
  logic               resp_o;
  logic [31:0]        address_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  address_i, line_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, address_o, burst_o, read_o, write_o
  );

  modport master (
    output address_i, line_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, burst_o, read_o, write_o
  );
endinterface

// File: rtl/mike_cacheline_adaptor.sv
// Splits a cacheline fill/writeback into n_beats memory beats and reassembles fills.
// All bus outputs are registered; resp_o pulses for one cycle when a line completes.
module mike_cacheline_adaptor #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input logic                    clk,
  input logic                    rst,
  mike_cacheline_adaptor_if.slave bus
);

  localparam int unsigned n_beats = s_line / s_burst;
  localparam int unsigned BeatW   = $clog2(n_beats);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e             r_state;
  logic [BeatW-1:0]   r_beat;
  logic [s_line-1:0]  r_buf;
  logic [31:0]        r_addr;
  logic               r_resp;
  logic               r_read;
  logic               r_write;
  logic [s_burst-1:0] r_burst;

  logic [BeatW-1:0]   w_beat_nxt;
  logic               w_last;

  assign w_beat_nxt = r_beat + BeatW'(1);
  assign w_last     = (r_beat == BeatW'(n_beats - 1));

  assign bus.line_o    = r_buf;
  assign bus.resp_o    = r_resp;
  assign bus.address_o = r_addr;
  assign bus.burst_o   = r_burst;
  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_resp  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_burst <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_resp <= 1'b0;
          // Writeback takes priority when both requests arrive together.
          if (bus.write_i) begin
            r_addr  <= bus.address_i;
            r_buf   <= bus.line_i;
            r_beat  <= '0;
            r_write <= 1'b1;
            r_burst <= bus.line_i[s_burst-1:0];
            r_state <= StWrite;
          end else if (bus.read_i) begin
            r_addr  <= bus.address_i;
            r_beat  <= '0;
            r_read  <= 1'b1;
            r_state <= StRead;
          end
        end
        StRead: begin
          if (bus.resp_i) begin
            r_buf[r_beat*s_burst +: s_burst] <= bus.burst_i;
            r_beat <= w_beat_nxt;
            if (w_last) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StWrite: begin
          if (bus.resp_i) begin
            r_beat <= w_beat_nxt;
            if (w_last) begin
              r_write <= 1'b0;
              r_burst <= '0;
              r_resp  <= 1'b1;
              r_state <= StDone;
            end else begin
              // Present the following beat so burst_o stays a registered output.
              r_burst <= r_buf[w_beat_nxt*s_burst +: s_burst];
            end
          end
        end
        StDone: begin
          r_resp  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mike_cacheline_adaptor.sv
// Directed bench for mike_cacheline_adaptor: a transaction-level model is compared every
// cycle, and literal expectations pin fills, writebacks, gaps, priority and reset abort.
module tb_mike_cacheline_adaptor;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mike_cacheline_adaptor_if bus ();

  mike_cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Model: what is in flight (0 none, 1 fill, 2 writeback, 3 completing) and beats so far.
  int          m_kind;
  int          m_n;
  logic [63:0] m_w [4];
  logic [31:0] m_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind <= 0;
      m_n    <= 0;
      m_addr <= '0;
      for (int i = 0; i < 4; i++) m_w[i] <= '0;
    end else begin
      case (m_kind)
        0: begin
          if (bus.write_i) begin
            m_kind <= 2;
            m_n    <= 0;
            m_addr <= bus.address_i;
            for (int i = 0; i < 4; i++) m_w[i] <= bus.line_i[i*64 +: 64];
          end else if (bus.read_i) begin
            m_kind <= 1;
            m_n    <= 0;
            m_addr <= bus.address_i;
          end
        end
        1, 2: begin
          if (bus.resp_i) begin
            if (m_kind == 1) m_w[m_n] <= bus.burst_i;
            if (m_n == 3) begin
              m_kind <= 3;
              m_n    <= 0;
            end else begin
              m_n <= m_n + 1;
            end
          end
        end
        default: m_kind <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("mdl_line_o", bus.line_o, {m_w[3], m_w[2], m_w[1], m_w[0]});
      chk("mdl_resp_o", 256'(bus.resp_o), 256'(m_kind == 3));
      chk("mdl_read_o", 256'(bus.read_o), 256'(m_kind == 1));
      chk("mdl_write_o", 256'(bus.write_o), 256'(m_kind == 2));
      chk("mdl_address_o", 256'(bus.address_o), 256'(m_addr));
      chk("mdl_burst_o", 256'(bus.burst_o), (m_kind == 2) ? 256'(m_w[m_n]) : 256'(0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic r, input logic [63:0] d);
    bus.resp_i  = r;
    bus.burst_i = d;
    cyc();
  endtask

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;

  logic [63:0]  wv   [4];
  logic         gpat [7];
  logic [63:0]  gdat [7];
  int           k;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    cyc();
    cyc();
    chk("rst_line_o", bus.line_o, 256'(0));
    chk("rst_ctrl", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    chk("rst_addr_burst", 256'({bus.address_o, bus.burst_o}), 256'(0));
    rst = 1'b1;
    cyc();

    // Fill with back-to-back beats.
    bus.address_i = 32'h0000_1A40;
    bus.read_i    = 1'b1;
    cyc();
    chk("t1_read_o", 256'(bus.read_o), 256'(1));
    chk("t1_address_o", 256'(bus.address_o), 256'(32'h0000_1A40));
    beat(1'b1, W1);
    beat(1'b1, W2);
    beat(1'b1, W3);
    chk("t1_resp_early", 256'(bus.resp_o), 256'(0));
    beat(1'b1, W4);
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    chk("t1_resp_o", 256'(bus.resp_o), 256'(1));
    chk("t1_read_done", 256'(bus.read_o), 256'(0));
    chk("t1_line_o", bus.line_o, {W4, W3, W2, W1});
    cyc();
    chk("t1_resp_once", 256'(bus.resp_o), 256'(0));
    chk("t1_line_hold", bus.line_o, {W4, W3, W2, W1});

    // Writeback, beat 0 is the low word.
    wv[0] = 64'hA; wv[1] = 64'hB; wv[2] = 64'hC; wv[3] = 64'hD;
    bus.address_i = 32'h0000_3000;
    bus.line_i    = {wv[3], wv[2], wv[1], wv[0]};
    bus.write_i   = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_write_o", 256'(bus.write_o), 256'(1));
      chk("t2_burst_o", 256'(bus.burst_o), 256'(wv[i]));
      beat(1'b1, 64'h0);
    end
    bus.resp_i  = 1'b0;
    bus.write_i = 1'b0;
    chk("t2_resp_o", 256'(bus.resp_o), 256'(1));
    chk("t2_write_done", 256'({bus.write_o, bus.burst_o}), 256'(0));
    cyc();

    // Fill with gaps in the beat strobe.
    gpat[0] = 1; gpat[1] = 0; gpat[2] = 0; gpat[3] = 1; gpat[4] = 1; gpat[5] = 0; gpat[6] = 1;
    gdat[0] = 64'h5555_0000_0000_0005; gdat[1] = 64'hDEAD_BEEF_0000_0001;
    gdat[2] = 64'hDEAD_BEEF_0000_0002; gdat[3] = 64'h6666_0000_0000_0006;
    gdat[4] = 64'h7777_0000_0000_0007; gdat[5] = 64'hDEAD_BEEF_0000_0003;
    gdat[6] = 64'h8888_0000_0000_0008;
    bus.address_i = 32'h0000_2000;
    bus.read_i    = 1'b1;
    cyc();
    for (int i = 0; i < 7; i++) begin
      chk("t3_read_o", 256'(bus.read_o), 256'(1));
      chk("t3_no_resp", 256'(bus.resp_o), 256'(0));
      beat(gpat[i], gdat[i]);
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    chk("t3_resp_o", 256'(bus.resp_o), 256'(1));
    chk("t3_line_o", bus.line_o, {gdat[6], gdat[4], gdat[3], gdat[0]});
    cyc();

    // Simultaneous requests: writeback wins; spurious resp_i in DONE.
    bus.address_i = 32'h0000_4020;
    bus.line_i    = {64'h44, 64'h33, 64'h22, 64'h11};
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    cyc();
    chk("t4_write_o", 256'(bus.write_o), 256'(1));
    chk("t4_read_o", 256'(bus.read_o), 256'(0));
    for (int i = 0; i < 4; i++) beat(1'b1, 64'hFFFF);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    chk("t4_resp_o", 256'(bus.resp_o), 256'(1));
    cyc();

    // Spurious strobes while idle.
    for (int i = 0; i < 3; i++) beat(1'b1, 64'hBAD0 + 64'(i));
    bus.resp_i = 1'b0;
    chk("t5_idle_ctrl", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    chk("t5_line_o", bus.line_o, {64'h44, 64'h33, 64'h22, 64'h11});

    // Reset aborts a fill after two beats.
    bus.address_i = 32'h0000_5000;
    bus.read_i    = 1'b1;
    cyc();
    beat(1'b1, 64'hAAAA);
    beat(1'b1, 64'hBBBB);
    bus.resp_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_ctrl", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    chk("t6_async_line", bus.line_o, 256'(0));
    chk("t6_async_addr", 256'({bus.address_o, bus.burst_o}), 256'(0));
    bus.read_i = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("t6_no_stale", 256'(bus.resp_o), 256'(0));
    bus.address_i = 32'h0000_6040;
    bus.read_i    = 1'b1;
    cyc();
    k = 0;
    beat(1'b1, 64'h0101);
    beat(1'b1, 64'h0202);
    beat(1'b1, 64'h0303);
    beat(1'b1, 64'h0404);
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    chk("t6_resp_o", 256'(bus.resp_o), 256'(1));
    chk("t6_line_o", bus.line_o, {64'h0404, 64'h0303, 64'h0202, 64'h0101});
    chk("t6_address_o", 256'(bus.address_o), 256'(32'h0000_6040));
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
